// File: rtl/pool2x2_stream_if.sv
// Pixel stream bundle for pool2x2_stream: input pixel handshake plus the
// pooled-output handshake carrying data and the next-layer write address.
interface pool2x2_stream_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;

  // Producer of input pixels / consumer of pooled pixels.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_addr
  );

  // The pooling engine.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 pooling engine (max or floor-average, signed or unsigned).
// Consumes a raster pixel stream, emits one pooled pixel per 2x2 window
// with a write address of base_addr + window index.
module pool2x2_stream #(
  parameter int DATA_WIDTH = 12,
  parameter int IN_W       = 10,
  parameter int IN_H       = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  pool2x2_stream_if.slave       px,
  output logic                  busy,
  output logic                  done
);

  if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_w
    $error("pool2x2_stream: IN_W must be even and at least 2");
  end
  if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_h
    $error("pool2x2_stream: IN_H must be even and at least 2");
  end

  localparam int OW = IN_W / 2;
  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);
  localparam int LW = (OW > 1) ? $clog2(OW) : 1;
  localparam int HW = DATA_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_FIN} state_t;

  state_t                state_q;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] oidx_q;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [DATA_WIDTH-1:0] pair_q;
  logic [HW-1:0]         line_buf_q [OW];
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  in_ready;
  logic                  acc;
  logic                  win_done;
  logic                  last_col;
  logic                  last_row;
  logic [LW-1:0]         lb_idx;
  logic [HW-1:0]         pix_x;
  logic [HW-1:0]         pair_x;
  logic [HW-1:0]         lb_x;
  logic [HW-1:0]         h_d;
  logic [SW-1:0]         sum_d;
  logic [DATA_WIDTH-1:0] res_d;

  function automatic logic [HW-1:0] ext1(input logic [DATA_WIDTH-1:0] v);
    return (SIGNED != 0) ? {v[DATA_WIDTH-1], v} : {1'b0, v};
  endfunction

  function automatic logic [SW-1:0] ext2(input logic [HW-1:0] v);
    return (SIGNED != 0) ? {v[HW-1], v} : {1'b0, v};
  endfunction

  function automatic logic gt(input logic [HW-1:0] a, input logic [HW-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign in_ready = (state_q == S_RUN) && (!out_valid_q || px.out_ready);
  assign acc      = px.in_valid && in_ready;
  assign win_done = acc && col_q[0] && row_q[0];
  assign last_col = (col_q == CW'(IN_W - 1));
  assign last_row = (row_q == RW'(IN_H - 1));
  assign lb_idx   = LW'(col_q >> 1);

  // Horizontal then vertical combine of the current window.
  always_comb begin
    pix_x  = ext1(px.in_data);
    pair_x = ext1(pair_q);
    if (mode_q) h_d = pair_x + pix_x;
    else        h_d = gt(pix_x, pair_x) ? pix_x : pair_x;
    lb_x  = line_buf_q[lb_idx];
    sum_d = ext2(lb_x) + ext2(h_d);
    if (mode_q) begin
      // Arithmetic shift gives floor toward -inf for signed sums.
      if (SIGNED != 0) res_d = DATA_WIDTH'($signed(sum_d) >>> 2);
      else             res_d = DATA_WIDTH'(sum_d >> 2);
    end else begin
      res_d = DATA_WIDTH'(gt(lb_x, h_d) ? lb_x : h_d);
    end
  end

  // Pair register and line buffer of horizontal partial results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
      for (int unsigned i = 0; i < OW; i++) line_buf_q[i] <= '0;
    end else if (acc) begin
      if (!col_q[0])      pair_q <= px.in_data;
      else if (!row_q[0]) line_buf_q[lb_idx] <= h_d;
    end
  end

  // Frame FSM, raster counters and the single-entry output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      base_q      <= '0;
      oidx_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            mode_q  <= mode;
            base_q  <= base_addr;
            oidx_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (acc) begin
            if (last_col) begin
              col_q <= '0;
              if (last_row) state_q <= S_FLUSH;
              else          row_q   <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (!out_valid_q) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Window index counter replaces orow*(IN_W/2)+ocol: both step by one per output.
      if (win_done) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res_d;
        out_addr_q  <= base_q + oidx_q;
        oidx_q      <= oidx_q + 1'b1;
      end else if (out_valid_q && px.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign px.in_ready  = in_ready;
  assign px.out_valid = out_valid_q;
  assign px.out_data  = out_data_q;
  assign px.out_addr  = out_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: three instances (4x4 unsigned, 4x4 signed,
// 10x10 default) share stimulus; a window-level model predicts outputs.
module tb_pool2x2_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic        mode = 1'b0;
  logic [11:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  bit          ready_rand = 1'b0;
  int          cur = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          pix[$];
  int          exp_data[$];
  int          exp_addr[$];
  int          got_data[$];
  int          got_addr[$];

  logic        c_in_ready, c_out_valid, c_busy, c_done;
  logic [11:0] c_out_data, c_out_addr;

  always #5 clk = ~clk;

  pool2x2_stream_if #(.DATA_WIDTH(12), .ADDR_WIDTH(12)) if_a ();
  pool2x2_stream_if #(.DATA_WIDTH(12), .ADDR_WIDTH(12)) if_s ();
  pool2x2_stream_if #(.DATA_WIDTH(12), .ADDR_WIDTH(12)) if_c ();

  assign if_a.in_valid  = in_valid;
  assign if_a.in_data   = in_data;
  assign if_a.out_ready = out_ready;
  assign if_s.in_valid  = in_valid;
  assign if_s.in_data   = in_data;
  assign if_s.out_ready = out_ready;
  assign if_c.in_valid  = in_valid;
  assign if_c.in_data   = in_data;
  assign if_c.out_ready = out_ready;

  pool2x2_stream #(.DATA_WIDTH(12), .IN_W(4), .IN_H(4), .ADDR_WIDTH(12), .SIGNED(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .base_addr(base_addr),
    .px(if_a.slave), .busy(busy_v[0]), .done(done_v[0]));
  pool2x2_stream #(.DATA_WIDTH(12), .IN_W(4), .IN_H(4), .ADDR_WIDTH(12), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .base_addr(base_addr),
    .px(if_s.slave), .busy(busy_v[1]), .done(done_v[1]));
  pool2x2_stream #(.DATA_WIDTH(12), .IN_W(10), .IN_H(10), .ADDR_WIDTH(12), .SIGNED(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode), .base_addr(base_addr),
    .px(if_c.slave), .busy(busy_v[2]), .done(done_v[2]));

  // View of whichever instance is currently being exercised.
  always_comb begin
    c_in_ready = 1'b0; c_out_valid = 1'b0; c_busy = 1'b0; c_done = 1'b0;
    c_out_data = '0;   c_out_addr = '0;
    case (cur)
      0: begin c_in_ready = if_a.in_ready; c_out_valid = if_a.out_valid; c_out_data = if_a.out_data;
               c_out_addr = if_a.out_addr; c_busy = busy_v[0]; c_done = done_v[0]; end
      1: begin c_in_ready = if_s.in_ready; c_out_valid = if_s.out_valid; c_out_data = if_s.out_data;
               c_out_addr = if_s.out_addr; c_busy = busy_v[1]; c_done = done_v[1]; end
      default: begin c_in_ready = if_c.in_ready; c_out_valid = if_c.out_valid; c_out_data = if_c.out_data;
               c_out_addr = if_c.out_addr; c_busy = busy_v[2]; c_done = done_v[2]; end
    endcase
  end

  // Downstream acceptance: always ready or pseudo-random.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic int sv(input int x, input bit sgn);
    return (sgn && x >= 2048) ? x - 4096 : x;
  endfunction

  // Expected pooled stream for the whole frame held in pix[].
  task automatic build_expected(input int w, input int h, input bit md, input bit sgn, input int base);
    exp_data.delete();
    exp_addr.delete();
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        int v[4];
        int s;
        int m;
        int q;
        v[0] = sv(pix[2*r*w + 2*c], sgn);
        v[1] = sv(pix[2*r*w + 2*c + 1], sgn);
        v[2] = sv(pix[(2*r+1)*w + 2*c], sgn);
        v[3] = sv(pix[(2*r+1)*w + 2*c + 1], sgn);
        s = 0;
        m = v[0];
        foreach (v[k]) begin
          s += v[k];
          if (v[k] > m) m = v[k];
        end
        if (md) q = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        else    q = m;
        exp_data.push_back(q & 'hFFF);
        exp_addr.push_back((base + r * (w / 2) + c) & 'hFFF);
      end
    end
  endtask

  // Compares every output transfer and stall behaviour against the model.
  task automatic monitor();
    bit prev_stall = 1'b0;
    int pd = 0;
    int pa = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("stall_valid", c_out_valid, 1);
        chk("stall_data", c_out_data, pd);
        chk("stall_addr", c_out_addr, pa);
      end
      if (c_out_valid && !out_ready) chk("in_ready_backpressure", c_in_ready, 0);
      if (c_out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got data 0x%0h addr 0x%0h expected none", c_out_data, c_out_addr);
        end else begin
          int ed = exp_data.pop_front();
          int ea = exp_addr.pop_front();
          chk("out_data", c_out_data, ed);
          chk("out_addr", c_out_addr, ea);
        end
        got_data.push_back(c_out_data);
        got_addr.push_back(c_out_addr);
      end
      if (c_done) begin
        done_cnt++;
        chk("busy_low_at_done", c_busy, 0);
      end
      prev_stall = c_out_valid && !out_ready;
      pd = c_out_data;
      pa = c_out_addr;
    end
  endtask

  task automatic run_frame(input int which, input bit md, input int base, input int w, input int h,
                           input int n_send, input int poke, input bit gaps, output int cycles);
    int idx = 0;
    bit fire;
    bit poked = 1'b0;
    cur = which;
    got_data.delete();
    got_addr.delete();
    done_cnt = 0;
    build_expected(w, h, md, which == 1, base);
    @(posedge clk); #1;
    mode = md;
    base_addr = 12'(base);
    start_v[which] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    in_data = 12'(pix[0]);
    cycles = 0;
    while (idx < n_send) begin
      @(negedge clk);
      fire = in_valid && c_in_ready;
      @(posedge clk); #1;
      cycles++;
      start_v = '0;
      if (fire) idx++;
      if (idx == poke && !poked) begin
        poked = 1'b1;
        start_v[which] = 1'b1;
        mode = ~md;
      end
      if (idx < n_send) begin
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data = 12'(pix[idx]);
      end else begin
        in_valid = 1'b0;
      end
      if (cycles > 3000) begin
        checks++;
        errors++;
        $display("FAIL input_timeout: accepted %0d expected %0d", idx, n_send);
        break;
      end
    end
    in_valid = 1'b0;
    start_v = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected one within 500 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("leftover_expected", exp_data.size(), 0);
    chk("busy_after_done", c_busy, 0);
  endtask

  initial begin
    int cyc;
    int lit_max[4]  = '{5, 7, 13, 15};
    int lit_avg[4]  = '{2, 4, 10, 12};
    int lit_savg[4] = '{'hFFD, 'h000, 'h000, 'h800};
    int lit_smax[4] = '{'hFFF, 'h7FF, 'h006, 'h800};
    int spix[16]    = '{'hFFF, 'hFFE, 'h7FF, 'h800,
                        'hFFD, 'hFFC, 'h001, 'h002,
                        'hFFB, 'h005, 'h800, 'h800,
                        'hFFA, 'h006, 'h800, 'h800};
    fork
      monitor();
    join_none

    // Reset state of all instances.
    #22;
    chk("reset_a_ctrl", {if_a.out_valid, if_a.in_ready, busy_v[0], done_v[0]}, 0);
    chk("reset_a_data", if_a.out_data, 0);
    chk("reset_a_addr", if_a.out_addr, 0);
    chk("reset_s_ctrl", {if_s.out_valid, if_s.in_ready, busy_v[1], done_v[1]}, 0);
    chk("reset_c_ctrl", {if_c.out_valid, if_c.in_ready, busy_v[2], done_v[2]}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_in_ready", {if_a.in_ready, if_s.in_ready, if_c.in_ready}, 0);

    // 4x4 unsigned max, full throughput.
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(i);
    ready_rand = 1'b0;
    run_frame(0, 1'b0, 'h100, 4, 4, 16, -1, 1'b0, cyc);
    wait_done();
    chk("a_max_throughput", cyc, 16);
    chk("a_max_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("a_max_data_lit", got_data[i], lit_max[i]);
      chk("a_max_addr_lit", got_addr[i], 'h100 + i);
    end

    // 4x4 unsigned average.
    run_frame(0, 1'b1, 'h100, 4, 4, 16, -1, 1'b0, cyc);
    wait_done();
    chk("a_avg_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) chk("a_avg_data_lit", got_data[i], lit_avg[i]);

    // 4x4 signed average and max.
    pix.delete();
    foreach (spix[i]) pix.push_back(spix[i]);
    run_frame(1, 1'b1, 'h000, 4, 4, 16, -1, 1'b0, cyc);
    wait_done();
    chk("s_avg_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) chk("s_avg_data_lit", got_data[i], lit_savg[i]);
    run_frame(1, 1'b0, 'h000, 4, 4, 16, -1, 1'b0, cyc);
    wait_done();
    chk("s_max_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) chk("s_max_data_lit", got_data[i], lit_smax[i]);

    // 10x10 max with backpressure, input gaps and address wrap past 0xFFF.
    pix.delete();
    for (int i = 0; i < 100; i++) pix.push_back((i * 173 + 29) & 'hFFF);
    ready_rand = 1'b1;
    run_frame(2, 1'b0, 'hFF0, 10, 10, 100, -1, 1'b1, cyc);
    wait_done();
    chk("c_max_count", got_data.size(), 25);
    for (int i = 0; i < 25; i++) chk("c_max_addr_seq", got_addr[i], ('hFF0 + i) & 'hFFF);

    // Abort after 37 accepted pixels.
    pix.delete();
    for (int i = 0; i < 100; i++) pix.push_back((i * 311 + 5) & 'hFFF);
    run_frame(2, 1'b0, 'h050, 10, 10, 37, -1, 1'b1, cyc);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {if_c.out_valid, if_c.in_ready, busy_v[2], done_v[2]}, 0);
    chk("abort_data", if_c.out_data, 0);
    chk("abort_addr", if_c.out_addr, 0);
    exp_data.delete();
    exp_addr.delete();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle_busy", busy_v[2], 0);

    // Fresh average frame after the abort.
    pix.delete();
    for (int i = 0; i < 100; i++) pix.push_back((i * 91 + 7) & 'hFFF);
    run_frame(2, 1'b1, 'h020, 10, 10, 100, -1, 1'b1, cyc);
    wait_done();
    chk("c_avg_count", got_data.size(), 25);

    // start during RUN with mode flipped is ignored.
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(i);
    ready_rand = 1'b0;
    repeat (2) @(posedge clk);
    run_frame(0, 1'b0, 'h100, 4, 4, 16, 6, 1'b0, cyc);
    wait_done();
    chk("poke_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) chk("poke_max_data_lit", got_data[i], lit_max[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
